// File: rtl/cla_pkg.sv
// Shared constants and stage-register layout for the pipelined CLA adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cla_pkg;

  localparam int WIDTH   = 16;
  localparam int GROUP   = 4;
  localparam int NGROUPS = WIDTH / GROUP;

  // Per-stage register contents: p/g per bit, c[0] is carry-in, c[WIDTH] is carry-out
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   c;
    logic             cin;
  } stage_t;

endpackage

// File: rtl/clu4.sv
// 4-bit carry-lookahead unit: bit carries plus block propagate/generate.
// Latency: purely combinational.
// Backpressure: not applicable.
module clu4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       ci,
  output logic [4:1] c,
  output logic       P,
  output logic       G
);

  // Flattened lookahead: every carry is a two-level function of p, g and ci
  always_comb begin
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    P    = &p;
    G    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/cla_pipe16.sv
// 16-bit carry-lookahead adder, three register stages (p/g, carries, sum/flags).
// Latency: result valid on the third edge counting the accepting edge; one result per cycle.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready that same cycle.
module cla_pipe16 #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  import cla_pkg::*;

  // The lookahead tree is built for exactly four 4-bit groups
  if (WIDTH != cla_pkg::WIDTH || GROUP != cla_pkg::GROUP || (WIDTH % GROUP) != 0) begin : g_param_check
    $error("cla_pipe16: only WIDTH=16 and GROUP=4 are supported");
  end

  stage_t             r_s1;
  stage_t             r_s2;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  stage_t             w_s1_nxt;
  stage_t             w_s2_nxt;
  logic               w_stall;
  logic               w_en;
  logic [WIDTH:1]     w_c;
  logic [NGROUPS-1:0] w_gp;
  logic [NGROUPS-1:0] w_gg;
  logic [NGROUPS:0]   w_gci;
  logic               w_blk_p;
  logic               w_blk_g;
  logic               w_unused;

  // A held result blocks the whole pipe; nothing moves until it is taken
  assign w_stall  = r_out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = w_en;

  // S1 next state: operands reduced to per-bit propagate/generate; bubbles carry zero data
  always_comb begin
    w_s1_nxt       = '0;
    w_s1_nxt.valid = in_valid;
    if (in_valid) begin
      w_s1_nxt.p   = a ^ b;
      w_s1_nxt.g   = a & b;
      w_s1_nxt.cin = cin;
    end
  end

  // In-group lookahead; each group's carry-in comes from the inter-group unit
  for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
    clu4 u_clu_grp (
      .p  (r_s1.p[k*GROUP +: GROUP]),
      .g  (r_s1.g[k*GROUP +: GROUP]),
      .ci (w_gci[k]),
      .c  (w_c[k*GROUP+1 +: GROUP]),
      .P  (w_gp[k]),
      .G  (w_gg[k])
    );
  end

  // Inter-group lookahead over the group P/G terms, so no carry ripples between groups
  assign w_gci[0] = r_s1.cin;
  clu4 u_clu_top (
    .p  (w_gp),
    .g  (w_gg),
    .ci (r_s1.cin),
    .c  (w_gci[NGROUPS:1]),
    .P  (w_blk_p),
    .G  (w_blk_g)
  );

  // S2 next state: S1 contents plus the full carry vector, c[0] being carry-in
  always_comb begin
    w_s2_nxt   = r_s1;
    w_s2_nxt.c = {w_c, r_s1.cin};
  end

  // Stage 1 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
    end else if (w_en) begin
      r_s1 <= w_s1_nxt;
    end
  end

  // Stage 2 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2 <= '0;
    end else if (w_en) begin
      r_s2 <= w_s2_nxt;
    end
  end

  // Stage 3 register: sum and flags, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s2.valid;
      r_sum       <= r_s2.p ^ r_s2.c[WIDTH-1:0];
      r_cout      <= r_s2.c[WIDTH];
      r_ovf       <= r_s2.c[WIDTH] ^ r_s2.c[WIDTH-1];
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  // Redundant copies (g after carries are known, block P/G, duplicate c16) are not needed downstream
  assign w_unused = ^{r_s2.g, r_s2.cin, w_gci[NGROUPS], w_blk_p, w_blk_g};

endmodule

// File: tb/tb_cla_pipe16.sv
module tb_cla_pipe16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  cla_pipe16 #(.WIDTH(16), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single operand set followed by bubbles: result on the third edge, then idle again
  task automatic one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                     input logic vc, input logic [15:0] es, input logic ec, input logic eo);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    step();
    chk({tag, "_early"}, out_valid, 0);
    step();
    chk({tag, "_vld"},  out_valid, 1);
    chk({tag, "_sum"},  sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"},  ovf, eo);
    step();
    chk({tag, "_bubble"}, out_valid, 0);
  endtask

  initial begin
    logic [15:0] exp_q[$];
    logic [15:0] t;
    int got, sent, first_k, last_k;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Directed single vectors
    one("ffff_p1",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    one("7fff_p1",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    one("8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    one("ffff_cin",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    one("mix_cin",   16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    one("aaaa_5555", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    one("neg_neg",   16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back stream of (i, 2i)
    got = 0; first_k = -1; last_k = -1;
    for (int k = 0; k < 14; k++) begin
      if (k < 8) begin
        in_valid = 1'b1; a = 16'(k + 1); b = 16'(2 * (k + 1));
      end else begin
        in_valid = 1'b0; a = '0; b = '0;
      end
      cin = 1'b0;
      if (out_valid) begin
        chk("stream_sum", sum, 3 * (got + 1));
        got++;
        last_k = k;
        if (first_k < 0) first_k = k;
      end
      step();
    end
    chk("stream_cnt", got, 8);
    chk("stream_first", first_k, 3);
    chk("stream_contig", last_k - first_k, 7);

    // Stream with a four-cycle consumer stall
    got = 0; sent = 0;
    for (int k = 0; k < 30; k++) begin
      out_ready = !(k >= 4 && k < 8);
      if (sent < 8) begin
        in_valid = 1'b1;
        a = 16'h0F00 + 16'(sent * 16'h0111);
        b = 16'h7000 - 16'(sent * 16'h0021);
      end else begin
        in_valid = 1'b0; a = '0; b = '0;
      end
      #1;
      if (k >= 4 && k < 8) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
      end
      if (k == 8) chk("release_in_ready", in_ready, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stall_extra_out", out_valid, 0);
        end else begin
          chk("stall_sum", sum, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        t = a + b;
        exp_q.push_back(t);
        sent++;
      end
      step();
    end
    out_ready = 1'b1;
    chk("stall_sent", sent, 8);
    chk("stall_got", got, 8);
    chk("stall_drained", out_valid, 0);

    // Reset with three results in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'h1111 * 16'(i + 1); b = 16'h0101; cin = 1'b0;
      step();
    end
    in_valid = 1'b0; a = '0; b = '0;
    chk("inflight_vld", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_ovf", ovf, 0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("postrst_idle", out_valid, 0);
    end
    one("postrst_first", 16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
